muldiv_seq: RTL and testbench

- Multi-cycle sequencer for the RV32M multiply and divide instructions.
- Performs every add, subtract and negate step on the core's shared ALU, so no separate adder is needed.
- Sits beside the EX stage. While busy=1 the core stalls and muxes the ALU inputs from this block's alu_* ports.
- Returns a 32-bit result with a one-cycle done pulse.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the RV32M multiply/divide sequencer
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [2:0] ALU_OP_ADD = 3'b000;
    localparam int         ITER_COUNT = 32;
    localparam int         CNT_W      = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEG_A,
        S_NEG_B,
        S_ITER,
        S_FIX_LO,
        S_FIX_HI,
        S_DONE
    } state_e;

    function automatic logic rs1_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - RV32M multi-cycle mul/div sequencer driving the core's shared ALU
// Define MULDIV_EARLY_OUT_EN to let a multiply with a zero operand take the one-cycle fast path.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic             alu_switch_o,
    output logic [2:0]       alu_op_o,
    input  logic [WIDTH-1:0] alu_o_i,
    input  logic             alu_c_i
);

    if (WIDTH != 32) begin : g_width_check
        $error("muldiv_seq supports WIDTH=32 only");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         f3_q, f3_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic               sa_q, sa_d, sb_q, sb_d, lz_q, lz_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic               sw_q, sw_d;

    logic               fast_hit;
    logic [WIDTH-1:0]   fast_res;
    logic               div_zero, div_ovf, mul_zero;
    logic [WIDTH-1:0]   rem_sh, quot_sh;
    logic               neg_lo, neg_hi, sel_hi;

    assign div_zero = funct3_i[2] && (rs2_i == '0);
    assign div_ovf  = ((funct3_i == F3_DIV) || (funct3_i == F3_REM))
                      && (rs1_i == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2_i == '1);
`ifdef MULDIV_EARLY_OUT_EN
    assign mul_zero = !funct3_i[2] && ((rs1_i == '0) || (rs2_i == '0));
`else
    assign mul_zero = 1'b0;
`endif
    assign fast_hit = div_zero || div_ovf || mul_zero;

    always_comb begin
        fast_res = '0;
        if (div_zero)     fast_res = funct3_i[1] ? rs1_i : '1;
        else if (div_ovf) fast_res = funct3_i[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    end

    // Restoring divide keeps {rem, quot} in {hi, lo}; the bit leaving rem makes it 33 bits wide.
    assign rem_sh  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    assign quot_sh = {lo_q[WIDTH-2:0], 1'b0};
    assign neg_lo  = sa_q ^ sb_q;
    assign neg_hi  = f3_q[2] ? sa_q : (sa_q ^ sb_q);
    assign sel_hi  = !((f3_q == F3_MUL) || (f3_q == F3_DIV) || (f3_q == F3_DIVU));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        lz_d    = lz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    f3_d = funct3_i;
                    a_d  = rs1_i;
                    b_d  = rs2_i;
                    sa_d = rs1_signed(funct3_i) && rs1_i[WIDTH-1];
                    sb_d = rs2_signed(funct3_i) && rs2_i[WIDTH-1];
                    if (fast_hit) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        res_d   = fast_res;
                    end else begin
                        state_d = S_NEG_A;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_NEG_A: begin
                if (sa_q) a_d = alu_o_i;
                state_d = S_NEG_B;
            end
            S_NEG_B: begin
                b_d     = sb_q ? alu_o_i : b_q;
                hi_d    = '0;
                lo_d    = f3_q[2] ? a_q : b_d;
                cnt_d   = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (f3_q[2]) begin
                    if (hi_q[WIDTH-1] || !alu_c_i) begin
                        hi_d = alu_o_i;
                        lo_d = quot_sh | {{(WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        hi_d = rem_sh;
                        lo_d = quot_sh;
                    end
                end else begin
                    hi_d = {alu_c_i, alu_o_i[WIDTH-1:1]};
                    lo_d = {alu_o_i[0], lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER_COUNT - 1)) state_d = S_FIX_LO;
            end
            S_FIX_LO: begin
                lz_d = (lo_q == '0);
                if (neg_lo) lo_d = alu_o_i;
                state_d = S_FIX_HI;
            end
            S_FIX_HI: begin
                if (neg_hi) hi_d = alu_o_i;
                res_d   = sel_hi ? hi_d : lo_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            res_d   = res_q;
        end
    end

    // ALU operands are registered, so they are derived from the state being entered.
    always_comb begin
        alu_a_d = '0;
        alu_b_d = '0;
        sw_d    = 1'b0;
        case (state_d)
            S_NEG_A: begin alu_b_d = a_d; sw_d = 1'b1; end
            S_NEG_B: begin alu_b_d = b_d; sw_d = 1'b1; end
            S_ITER: begin
                if (f3_d[2]) begin
                    alu_a_d = {hi_d[WIDTH-2:0], lo_d[WIDTH-1]};
                    alu_b_d = b_d;
                    sw_d    = 1'b1;
                end else begin
                    alu_a_d = hi_d;
                    alu_b_d = lo_d[0] ? a_d : '0;
                end
            end
            S_FIX_LO: begin alu_b_d = lo_d; sw_d = 1'b1; end
            S_FIX_HI: begin
                if (f3_d[2]) begin
                    alu_b_d = hi_d;
                    sw_d    = 1'b1;
                end else begin
                    alu_a_d = ~hi_d;
                    alu_b_d = {{(WIDTH-1){1'b0}}, lz_d};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            lz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            alu_a_q <= '0;
            alu_b_q <= '0;
            sw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            lz_q    <= lz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            sw_q    <= sw_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign result_o     = res_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_switch_o = sw_q;
    assign alu_op_o     = ALU_OP_ADD;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard bench for muldiv_seq with a behavioural shared ALU
module tb_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        start_i, flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i, rs2_i;
    logic        busy_o, done_o;
    logic [31:0] result_o, alu_a_o, alu_b_o;
    logic        alu_switch_o;
    logic [2:0]  alu_op_o;
    logic [31:0] alu_o_i;
    logic        alu_c_i;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .flush_i(flush_i),
        .funct3_i(funct3_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_switch_o(alu_switch_o),
        .alu_op_o(alu_op_o), .alu_o_i(alu_o_i), .alu_c_i(alu_c_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core ALU: add, or subtract with carry reporting borrow.
    always_comb begin
        if (alu_switch_o) {alu_c_i, alu_o_i} = {1'b0, alu_a_o} - {1'b0, alu_b_o};
        else              {alu_c_i, alu_o_i} = {1'b0, alu_a_o} + {1'b0, alu_b_o};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 0;
        if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
`ifdef MULDIV_EARLY_OUT_EN
        if (!f3[2] && (a == 0 || b == 0)) return 0;
`endif
        return 36;
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit poke);
        int lat, busy_cycles, exp_lat;
        bit got;
        logic [31:0] exp_res;
        @(negedge clk);
        start_i  = 1'b1;
        funct3_i = f3;
        rs1_i    = a;
        rs2_i    = b;
        exp_q.push_back(ref_model(f3, a, b));
        lat_q.push_back(ref_latency(f3, a, b));
        exp_lat = lat_q[$];
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        rs1_i    = $urandom();
        rs2_i    = $urandom();
        funct3_i = 3'($urandom_range(0, 7));
        lat = 0;
        busy_cycles = 0;
        got = 0;
        while (!got && lat < 100) begin
            @(negedge clk);
            if (poke) start_i = (lat == 5);
            if (done_o) got = 1;
            else begin
                if (lat == 0 && exp_lat != 0) begin
                    check("nega_alu_a", alu_a_o, 32'h0);
                    check("nega_alu_b", alu_b_o, a);
                    check("nega_sub", {31'b0, alu_switch_o}, 32'h1);
                end
                busy_cycles += int'(busy_o);
                lat++;
            end
        end
        start_i = 1'b0;
        check("done_seen", {31'b0, got}, 32'h1);
        if (got) begin
            exp_res = exp_q.pop_front();
            exp_lat = lat_q.pop_front();
            check($sformatf("result f3=%0d a=%h b=%h", f3, a, b), result_o, exp_res);
            check("latency", 32'(lat), 32'(exp_lat));
            check("busy_cycles", 32'(busy_cycles), 32'(exp_lat));
            check("busy_at_done", {31'b0, busy_o}, 32'h0);
            @(negedge clk);
            check("done_pulse", {31'b0, done_o}, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] prev;
        int done_hits;
        rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
        funct3_i = '0; rs1_i = '0; rs2_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'b0, busy_o}, 32'h0);
        check("rst_done", {31'b0, done_o}, 32'h0);
        check("rst_result", result_o, 32'h0);
        check("rst_alu_a", alu_a_o, 32'h0);
        check("rst_alu_b", alu_b_o, 32'h0);
        check("rst_alu_sw", {31'b0, alu_switch_o}, 32'h0);
        check("alu_op", {29'b0, alu_op_o}, 32'h0);
        rst_n = 1'b1;

        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 0);
        run_op(3'b001, 32'hFFFF_FFFD, 32'h0000_0007, 0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'b100, 32'hFFFF_FFEC, 32'h0000_0003, 0);
        run_op(3'b110, 32'hFFFF_FFEC, 32'h0000_0003, 0);
        run_op(3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 0);
        run_op(3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 0);
        run_op(3'b100, 32'h1234_5678, 32'h0, 0);
        run_op(3'b110, 32'h1234_5678, 32'h0, 0);
        run_op(3'b101, 32'hDEAD_BEEF, 32'h0, 0);
        run_op(3'b111, 32'hDEAD_BEEF, 32'h0, 0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'b000, 32'h0000_0000, 32'h1234_5678, 0);
        run_op(3'b100, 32'h0000_0064, 32'h0000_0007, 1);
        for (int i = 0; i < 10; i++) begin
            logic [31:0] ra, rb;
            ra = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom();
            rb = (i % 4 == 1) ? 32'($urandom_range(0, 9)) : $urandom();
            if (i % 5 == 2) rb = -rb;
            run_op(3'($urandom_range(0, 7)), ra, rb, 0);
        end

        prev = result_o;
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'b001; rs1_i = 32'h1357_9BDF; rs2_i = 32'h8642_0ACE;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        check("flush_busy", {31'b0, busy_o}, 32'h0);
        done_hits = 0;
        repeat (40) begin
            @(negedge clk);
            done_hits += int'(done_o);
        end
        check("flush_no_done", 32'(done_hits), 32'h0);
        check("flush_result", result_o, prev);

        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'h7777_7777; rs2_i = 32'h0000_0013;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy_o}, 32'h0);
        check("arst_result", result_o, 32'h0);
        check("arst_alu_a", alu_a_o, 32'h0);
        check("arst_alu_b", alu_b_o, 32'h0);
        check("arst_alu_sw", {31'b0, alu_switch_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'b110, 32'hFFFF_FF85, 32'h0000_000A, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
